// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the UART instruction loader.
//   loader_state_t  - loader FSM states (IDLE / LOAD / FINISH)
//   BYTES_PER_WORD  - received bytes per 32-bit instruction word
//   BYTE_IDX_W      - width of the byte-within-word index
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } loader_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: assembles UART bytes into little-endian 32-bit words and
// writes them to consecutive instruction-memory word addresses starting at 0
// while `flash` is high, holding the CPU pipeline for the whole load.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   flash            - load-mode request (level)
//   byte_received    - one-cycle strobe qualifying byte_data
//   byte_data        - received byte
//   imem_we          - one-cycle instruction-memory write enable
//   imem_addr        - word address of the write
//   imem_wdata       - assembled instruction word
//   cpu_hold         - stalls PC and IF/ID (high in LOAD and FINISH)
//   load_done        - one-cycle pulse when a load ends
//   word_count       - words written in the current or last load
//   err_partial      - sticky: a partial word was discarded
//   err_overflow     - sticky: more than IMEM_DEPTH words were sent
//
// Build option: define IMEM_LOADER_TIMEOUT_EN to discard a partial word after
// TIMEOUT_CYCLES idle cycles between bytes of one word.
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH     = 1024,
    parameter int unsigned ADDR_W         = $clog2(IMEM_DEPTH),
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flash,
    input  logic              byte_received,
    input  logic [7:0]        byte_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_partial,
    output logic              err_overflow
);

    loader_state_t         state;
    loader_state_t         state_next;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [31:0]           shift_reg;

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0]       FULL     = (ADDR_W+1)'(IMEM_DEPTH);

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_hold   = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (flash) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cpu_hold = 1'b1;
                if (!flash) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                cpu_hold   = 1'b1;
                load_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The write address is derived from word_count, so it stops advancing
    // (never wraps) once IMEM_DEPTH words have been written.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            word_count   <= '0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
            byte_idx     <= '0;
            shift_reg    <= '0;
`ifdef IMEM_LOADER_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (flash) begin
                        byte_idx     <= '0;
                        shift_reg    <= '0;
                        imem_addr    <= '0;
                        word_count   <= '0;
                        err_partial  <= 1'b0;
                        err_overflow <= 1'b0;
`ifdef IMEM_LOADER_TIMEOUT_EN
                        idle_cnt     <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (!flash) begin
                        if (byte_idx != '0) begin
                            err_partial <= 1'b1;
                        end
                        byte_idx  <= '0;
                        shift_reg <= '0;
`ifdef IMEM_LOADER_TIMEOUT_EN
                        idle_cnt  <= '0;
`endif
                    end else if (byte_received) begin
`ifdef IMEM_LOADER_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (byte_idx == LAST_IDX) begin
                            byte_idx  <= '0;
                            shift_reg <= '0;
                            if (word_count == FULL) begin
                                err_overflow <= 1'b1;
                            end else begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {byte_data, shift_reg[23:0]};
                                imem_addr  <= word_count[ADDR_W-1:0];
                                word_count <= word_count + 1'b1;
                            end
                        end else begin
                            shift_reg[byte_idx*8 +: 8] <= byte_data;
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
`ifdef IMEM_LOADER_TIMEOUT_EN
                    else if (byte_idx != '0) begin
                        if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            idle_cnt    <= '0;
                            byte_idx    <= '0;
                            shift_reg   <= '0;
                            err_partial <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
